// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, signed/unsigned per operation,
// valid/ready result handshake with backpressure and a flush that abandons any pending work.
module booth_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mul_signed,
   input  logic [WIDTH-1:0]     src1,
   input  logic [WIDTH-1:0]     src2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy
);

   localparam int NDIG = (WIDTH + 2) / 2;
   localparam int EW   = WIDTH + 2;
   localparam int AW   = 2 * WIDTH + 4;
   localparam int CW   = $clog2(NDIG + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        mcand_q, mcand_d;
   logic [EW:0]          mplier_q, mplier_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 accept;
   logic [EW-1:0]        ext1, ext2;
   logic [AW-1:0]        term, accSum;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      in_ready = !reset && !flush &&
                 ((state_q == IDLE) || ((state_q == DONE) && out_ready));
      accept   = in_valid && in_ready;

      ext1 = mul_signed ? {{2{src1[WIDTH-1]}}, src1} : {2'b00, src1};
      ext2 = mul_signed ? {{2{src2[WIDTH-1]}}, src2} : {2'b00, src2};

      // The multiplicand is pre-shifted by 2 every digit, so the term is already aligned.
      unique case (mplier_q[2:0])
         3'b001, 3'b010: term = mcand_q;
         3'b011:         term = mcand_q << 1;
         3'b100:         term = -(mcand_q << 1);
         3'b101, 3'b110: term = -mcand_q;
         default:        term = '0;
      endcase
      accSum = acc_q + term;

      unique case (state_q)
         BUSY: begin
            acc_d    = accSum;
            mcand_d  = mcand_q << 2;
            mplier_d = mplier_q >> 2;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(NDIG - 1)) begin
               result_d = accSum[2*WIDTH-1:0];
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         mcand_d  = {{(AW-EW){ext1[EW-1]}}, ext1};
         mplier_d = {ext2, 1'b0};
         acc_d    = '0;
         cnt_d    = '0;
         state_d  = BUSY;
      end

      // Flush outranks both accept and the output handshake; the held result is left untouched.
      if (flush) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == BUSY);
   assign result    = result_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed bench for booth_mul_iter (WIDTH=32): reset, signed/unsigned corner products,
// backpressure with same-edge accept, flush in BUSY and DONE, and reset during BUSY.
module tb_booth_mul_iter;

   localparam int WIDTH = 32;
   localparam int NDIG  = 17;

   logic                clk = 1'b0;
   logic                reset;
   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic                mul_signed;
   logic [WIDTH-1:0]    src1;
   logic [WIDTH-1:0]    src2;
   logic                out_valid;
   logic                out_ready;
   logic [2*WIDTH-1:0]  result;
   logic                busy;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   booth_mul_iter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .mul_signed(mul_signed),
      .src1(src1), .src2(src2),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents operands for one edge; the caller is left at the negedge after the accept edge.
   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input string tag);
      @(negedge clk);
      mul_signed = sgn;
      src1       = a;
      src2       = b;
      in_valid   = 1'b1;
      #1;
      checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits out the fixed latency, checking out_valid stays low until exactly edge NDIG.
   task automatic waitResult(input logic [63:0] exp, input string tag);
      repeat (NDIG - 1) @(negedge clk);
      checkOutput({tag, " early_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, " result"}, result, exp);
   endtask

   task automatic doMul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
      applyStimulus(sgn, a, b, tag);
      waitResult(exp, tag);
      @(negedge clk);
      checkOutput({tag, " consumed"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      bit seenValid;

      reset      = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      mul_signed = 1'b0;
      src1       = '0;
      src2       = '0;
      out_ready  = 1'b1;

      repeat (3) begin
         @(negedge clk);
         checkOutput("reset in_ready", 64'(in_ready), 64'd0);
      end
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset result", result, 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      reset = 1'b0;
      #1;
      checkOutput("post-reset in_ready", 64'(in_ready), 64'd1);

      doMul(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "s_m1xm1");
      doMul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "u_maxsq");
      doMul(1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, "s_minx1");
      doMul(1'b0, 32'h80000000, 32'h00000001, 64'h0000000080000000, "u_minx1");
      doMul(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, "s_minsq");
      doMul(1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFFFFFFFFF1, "s_m3x5");
      doMul(1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF80000000, "u_maxxmsb");

      // Backpressure, then a same-edge handshake and accept.
      out_ready = 1'b0;
      applyStimulus(1'b0, 32'h0000FFFF, 32'h0000FFFF, "bp");
      waitResult(64'h00000000FFFE0001, "bp");
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp hold valid", 64'(out_valid), 64'd1);
         checkOutput("bp hold result", result, 64'h00000000FFFE0001);
         checkOutput("bp in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      applyStimulus(1'b0, 32'd3, 32'd5, "bp_next");
      checkOutput("bp_next dropped", 64'(out_valid), 64'd0);
      checkOutput("bp_next busy", 64'(busy), 64'd1);
      waitResult(64'h000000000000000F, "bp_next");
      @(negedge clk);

      // Flush in the middle of BUSY.
      applyStimulus(1'b0, 32'h12345678, 32'h9ABCDEF0, "fl");
      repeat (7) @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("fl in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      checkOutput("fl busy", 64'(busy), 64'd0);
      seenValid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seenValid = 1'b1;
      end
      checkOutput("fl never valid", 64'(seenValid), 64'd0);
      doMul(1'b1, 32'd7, 32'd6, 64'd42, "fl_next");

      // Flush while a result waits in DONE: it is discarded though out_ready is high.
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'd9, 32'hFFFFFFFE, "fd");
      waitResult(64'hFFFFFFFFFFFFFFEE, "fd");
      @(negedge clk);
      flush     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("fd dropped", 64'(out_valid), 64'd0);
      checkOutput("fd result kept", result, 64'hFFFFFFFFFFFFFFEE);

      // Reset during BUSY clears the result as well.
      applyStimulus(1'b0, 32'd100, 32'd200, "rb");
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rb busy", 64'(busy), 64'd0);
      checkOutput("rb result", result, 64'd0);
      doMul(1'b0, 32'd100, 32'd200, 64'd20000, "rb_next");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
